// File: rtl/serdes_pkg.sv
// Shared definitions for the 10-bit serial link: symbol width, K28.5 comma
// encodings and the receive aligner state encoding.
package serdes_pkg;

  localparam int SYM_W = 10;

  localparam logic [SYM_W-1:0] K28_5_RDN = 10'b0011111010;
  localparam logic [SYM_W-1:0] K28_5_RDP = 10'b1100000101;

  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCKED
  } align_state_t;

endpackage

// File: rtl/serdes_comma_det.sv
// Combinational K28.5 detector, either running disparity.
module serdes_comma_det
  import serdes_pkg::*;
(
  input  logic [SYM_W-1:0] i_sym,
  output logic             o_match
);

  assign o_match = (i_sym == K28_5_RDN) || (i_sym == K28_5_RDP);

endmodule

// File: rtl/serdes_rx_align.sv
// Receive word aligner: shifts in serial bits, hunts for K28.5, locks the
// 10-bit boundary and emits aligned symbols with a valid strobe.
module serdes_rx_align
  import serdes_pkg::*;
#(
  parameter int LOCK_COMMAS   = 3,
  parameter int MISALIGN_MAX  = 2,
  parameter int CHECK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             serdes_rx,
  output logic [SYM_W-1:0] data_out,
  output logic             data_valid,
  output logic             is_comma,
  output logic             locked,
  output logic             align_err
);

  localparam int GOOD_W = $clog2(LOCK_COMMAS + 1);
  localparam int MISS_W = $clog2(MISALIGN_MAX + 1);
  localparam int TMR_W  = $clog2(CHECK_TIMEOUT + 1);

  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_COMMAS);
  localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);
  localparam logic [MISS_W-1:0] MISS_MAX  = MISS_W'(MISALIGN_MAX);
  localparam logic [MISS_W-1:0] MISS_ONE  = MISS_W'(1);
  localparam logic [TMR_W-1:0]  TMR_MAX   = TMR_W'(CHECK_TIMEOUT);
  localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
  localparam logic [3:0]        CNT_LAST  = 4'(SYM_W - 1);

  align_state_t      r_state, w_state_next;
  logic [SYM_W-1:0]  r_sr, w_sr_next;
  logic [3:0]        r_cnt, w_cnt_next;
  logic [GOOD_W-1:0] r_good, w_good_next, w_good_inc;
  logic [MISS_W-1:0] r_miss, w_miss_next, w_miss_inc;
  logic [TMR_W-1:0]  r_timer, w_timer_next, w_timer_inc;
  logic [SYM_W-1:0]  r_data, w_data_next;
  logic              r_valid, w_valid_next;
  logic              r_comma, w_comma_next;
  logic              r_err, w_err_next;
  logic              w_match;
  logic              w_boundary;

  // Match is judged on the registered window, so a symbol completed at edge E
  // is emitted at edge E+1.
  serdes_comma_det u_comma_det (
    .i_sym   (r_sr),
    .o_match (w_match)
  );

  // r_cnt counts bits shifted in since the window last held a full word.
  assign w_boundary  = (r_cnt == 4'd0);
  assign w_good_inc  = (r_good  == GOOD_LOCK) ? r_good  : r_good  + GOOD_ONE;
  assign w_miss_inc  = (r_miss  == MISS_MAX)  ? r_miss  : r_miss  + MISS_ONE;
  assign w_timer_inc = (r_timer == TMR_MAX)   ? r_timer : r_timer + TMR_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= HUNT;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_good  <= '0;
      r_miss  <= '0;
      r_timer <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_comma <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sr    <= w_sr_next;
      r_cnt   <= w_cnt_next;
      r_good  <= w_good_next;
      r_miss  <= w_miss_next;
      r_timer <= w_timer_next;
      r_data  <= w_data_next;
      r_valid <= w_valid_next;
      r_comma <= w_comma_next;
      r_err   <= w_err_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_sr_next    = r_sr;
    w_cnt_next   = r_cnt;
    w_good_next  = r_good;
    w_miss_next  = r_miss;
    w_timer_next = r_timer;
    w_data_next  = r_data;
    w_valid_next = 1'b0;
    w_comma_next = 1'b0;
    w_err_next   = 1'b0;

    if (!enable) begin
      w_state_next = HUNT;
      w_sr_next    = '0;
      w_cnt_next   = '0;
      w_good_next  = '0;
      w_miss_next  = '0;
      w_timer_next = '0;
      w_data_next  = '0;
    end else begin
      w_sr_next  = {r_sr[SYM_W-2:0], serdes_rx};
      w_cnt_next = (r_cnt == CNT_LAST) ? 4'd0 : r_cnt + 4'd1;
      case (r_state)
        HUNT: begin
          if (w_match) begin
            w_data_next  = r_sr;
            w_valid_next = 1'b1;
            w_comma_next = 1'b1;
            w_cnt_next   = 4'd1;
            w_good_next  = GOOD_ONE;
            w_miss_next  = '0;
            w_timer_next = '0;
            w_state_next = CHECK;
          end
        end
        CHECK: begin
          if (w_boundary) begin
            w_data_next  = r_sr;
            w_valid_next = 1'b1;
            w_comma_next = w_match;
            if (w_match) begin
              w_good_next  = w_good_inc;
              w_timer_next = '0;
              if (w_good_inc == GOOD_LOCK) begin
                w_miss_next  = '0;
                w_state_next = LOCKED;
              end
            end else begin
              w_timer_next = w_timer_inc;
              if (w_timer_inc == TMR_MAX) w_state_next = HUNT;
            end
          end else if (w_match) begin
            // Realign onto the off-boundary comma and restart the good count.
            w_err_next   = 1'b1;
            w_data_next  = r_sr;
            w_valid_next = 1'b1;
            w_comma_next = 1'b1;
            w_cnt_next   = 4'd1;
            w_good_next  = GOOD_ONE;
            w_timer_next = '0;
          end
        end
        LOCKED: begin
          if (w_boundary) begin
            w_data_next  = r_sr;
            w_valid_next = 1'b1;
            w_comma_next = w_match;
            if (w_match) w_miss_next = '0;
          end else if (w_match) begin
            w_err_next  = 1'b1;
            w_miss_next = w_miss_inc;
            if (w_miss_inc == MISS_MAX) w_state_next = HUNT;
          end
        end
        default: w_state_next = HUNT;
      endcase
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign is_comma   = r_comma;
  assign align_err  = r_err;
  assign locked     = (r_state == LOCKED);

endmodule

// File: tb/tb_serdes_rx_align.sv
// Directed bench for serdes_rx_align: comma hunt, lock, slip recovery,
// CHECK timeout, asynchronous reset and enable drop.
module tb_serdes_rx_align;

  localparam logic [9:0] K28 = 10'h0FA;
  localparam logic [9:0] D2A = 10'h2AA;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       serdes_rx;
  logic [9:0] data_out;
  logic       data_valid;
  logic       is_comma;
  logic       locked;
  logic       align_err;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int base;
  int p3;

  int         v_cyc[$];
  logic [9:0] v_data[$];
  logic       v_comma[$];
  logic       v_lock[$];
  logic       v_err[$];
  int         e_cyc[$];
  logic       e_lock[$];

  always #5 clk = ~clk;

  serdes_rx_align #(
    .LOCK_COMMAS   (3),
    .MISALIGN_MAX  (2),
    .CHECK_TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .serdes_rx  (serdes_rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .is_comma   (is_comma),
    .locked     (locked),
    .align_err  (align_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clr();
    v_cyc.delete();
    v_data.delete();
    v_comma.delete();
    v_lock.delete();
    v_err.delete();
    e_cyc.delete();
    e_lock.delete();
  endtask

  // Drive one bit, then log outputs just after the sampling edge.
  task automatic send_bit(input logic b);
    @(negedge clk);
    serdes_rx = b;
    @(posedge clk);
    #1;
    cyc++;
    if (data_valid) begin
      v_cyc.push_back(cyc);
      v_data.push_back(data_out);
      v_comma.push_back(is_comma);
      v_lock.push_back(locked);
      v_err.push_back(align_err);
      $display("word cyc=%0d data=%03h comma=%0b locked=%0b err=%0b",
               cyc, data_out, is_comma, locked, align_err);
    end
    if (align_err) begin
      e_cyc.push_back(cyc);
      e_lock.push_back(locked);
    end
    if (locked) check("locked_err_valid_excl", 32'(align_err & data_valid), 32'd0);
  endtask

  task automatic send_word(input logic [9:0] w);
    for (int i = 9; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"},  32'(data_out),   32'd0);
    check({tag, "_valid"}, 32'(data_valid), 32'd0);
    check({tag, "_comma"}, 32'(is_comma),   32'd0);
    check({tag, "_lock"},  32'(locked),     32'd0);
    check({tag, "_err"},   32'(align_err),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    serdes_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");

    // Idle ones never form a comma.
    @(negedge clk);
    rst    = 1'b0;
    enable = 1'b1;
    repeat (40) send_bit(1'b1);
    check("idle_nvalid", 32'(v_cyc.size()), 32'd0);
    check("idle_nerr",   32'(e_cyc.size()), 32'd0);
    check("idle_locked", 32'(locked),       32'd0);
    check("idle_data",   32'(data_out),     32'd0);

    // Three garbage bits then three back-to-back commas.
    clr();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_word(K28);
    base = cyc;
    send_word(K28);
    send_word(K28);
    send_word(D2A);
    check("lock_nvalid", 32'(v_cyc.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("lock_cyc",   32'(v_cyc[i]),   32'(base + 1 + 10 * i));
      check("lock_data",  32'(v_data[i]),  32'h0FA);
      check("lock_comma", 32'(v_comma[i]), 32'd1);
    end
    check("lock_rise", 32'({v_lock[0], v_lock[1], v_lock[2]}), 32'b001);
    check("lock_now",  32'(locked), 32'd1);

    // Data words while locked.
    clr();
    repeat (4) send_word(D2A);
    check("data_nvalid", 32'(v_cyc.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("data_cyc",   32'(v_cyc[i]),   32'(base + 31 + 10 * i));
      check("data_val",   32'(v_data[i]),  32'h2AA);
      check("data_comma", 32'(v_comma[i]), 32'd0);
    end
    check("data_locked", 32'(locked),       32'd1);
    check("data_nerr",   32'(e_cyc.size()), 32'd0);

    // One-bit slip before commas: two misses drop lock, third comma re-hunts.
    clr();
    p3 = cyc;
    send_bit(1'b1);
    send_word(K28);
    send_word(K28);
    send_word(K28);
    send_word(D2A);
    check("slip_nerr",   32'(e_cyc.size()), 32'd2);
    check("slip_err0",   32'(e_cyc[0]),     32'(p3 + 12));
    check("slip_err1",   32'(e_cyc[1]),     32'(p3 + 22));
    check("slip_lock0",  32'(e_lock[0]),    32'd1);
    check("slip_lock1",  32'(e_lock[1]),    32'd0);
    check("slip_nvalid", 32'(v_cyc.size()), 32'd4);
    check("slip_rcyc",   32'(v_cyc[3]),     32'(p3 + 32));
    check("slip_rdata",  32'(v_data[3]),    32'h0FA);
    check("slip_rcomma", 32'(v_comma[3]),   32'd1);
    check("slip_rlock",  32'(v_lock[3]),    32'd0);

    // CHECK timeout: 16 non-comma words, then silence.
    clr();
    repeat (18) send_word(D2A);
    check("tmo_nvalid", 32'(v_cyc.size()), 32'd16);
    check("tmo_last",   32'(v_cyc[15]),    32'(p3 + 192));
    check("tmo_locked", 32'(locked),       32'd0);
    check("tmo_nerr",   32'(e_cyc.size()), 32'd0);

    // Off-phase comma taken without align_err proves HUNT; then relock.
    clr();
    send_bit(1'b1);
    send_word(K28);
    send_word(K28);
    send_word(K28);
    repeat (5) send_bit(1'b1);
    check("hunt_nvalid", 32'(v_cyc.size()), 32'd3);
    check("hunt_comma",  32'(v_comma[0]),   32'd1);
    check("hunt_nerr",   32'(e_cyc.size()), 32'd0);
    check("relock_rise", 32'({v_lock[0], v_lock[1], v_lock[2]}), 32'b001);
    check("prerst_data", 32'(data_out), 32'h0FA);
    check("prerst_lock", 32'(locked),   32'd1);

    // Asynchronous reset mid-word clears outputs without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    check_zero("arst");
    @(negedge clk);
    rst = 1'b0;
    clr();
    send_bit(1'b1);
    send_word(K28);
    send_word(K28);
    send_word(K28);
    repeat (5) send_bit(1'b0);
    check("rst_relock_n",  32'(v_cyc.size()), 32'd3);
    check("rst_relock",    32'({v_lock[0], v_lock[1], v_lock[2]}), 32'b001);
    check("rst_relock_lk", 32'(locked), 32'd1);

    // Enable low for one cycle clears at the next edge, not before.
    @(negedge clk);
    enable    = 1'b0;
    serdes_rx = 1'b1;
    #1;
    check("en_pre_lock", 32'(locked),   32'd1);
    check("en_pre_data", 32'(data_out), 32'h0FA);
    @(posedge clk);
    #1;
    check_zero("en_low");
    @(negedge clk);
    enable = 1'b1;
    clr();
    send_word(K28);
    send_word(K28);
    send_word(K28);
    send_bit(1'b1);
    check("en_relock_n", 32'(v_cyc.size()), 32'd3);
    check("en_relock",   32'({v_lock[0], v_lock[1], v_lock[2]}), 32'b001);
    check("en_data",     32'(v_data[2]), 32'h0FA);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/serdes_rx_align.md
# serdes_rx_align

Receive-side word aligner for the 10-bit serial link. Samples `serdes_rx` one bit per `clk`, hunts for the K28.5 comma, and locks the 10-bit word boundary. Emits aligned 10-bit symbols with a valid strobe to the downstream 8b/10b decoder. It is the receiving end of the serialiser that drives `serdes_tx`; in loopback the two connect bit-for-bit on the same `clk`.

## Interface
- `LOCK_COMMAS`, default 3: aligned commas needed in CHECK before declaring lock (≥2).
- `MISALIGN_MAX`, default 2: misaligned commas tolerated in LOCKED before dropping to HUNT (≥1).
- `CHECK_TIMEOUT`, default 16: maximum words in CHECK without an aligned comma (≥1).
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  link enable; low synchronously forces the idle/HUNT condition.
- `serdes_rx`  in  1  serial data, one bit per `clk`, first transmitted bit first.
- `data_out`  out  10  aligned symbol; first received bit in `[9]`.
- `data_valid`  out  1  one-cycle strobe; `data_out` is valid this cycle.
- `is_comma`  out  1  qualifies `data_valid`; `data_out` is a K28.5.
- `locked`  out  1  high while in LOCKED.
- `align_err`  out  1  one-cycle pulse on each misaligned comma while in CHECK or LOCKED.

## Operation
- Shift register `sr[9:0]`: each enabled cycle, `sr <= {sr[8:0], serdes_rx}`. A comma match is `sr == 10'b0011111010` or `sr == 10'b1100000101`, evaluated on the updated `sr`.
- A word counter marks the boundary every 10 bits. A match on a boundary is an aligned comma. A match off a boundary is a misaligned comma.
- HUNT:
  - No word output.
  - On any match: emit it as a word (`is_comma=1`), set the boundary to this bit, good count = 1, go to CHECK.
- CHECK:
  - Emit every boundary word.
  - Aligned comma: good+1. When good reaches `LOCK_COMMAS`, go to LOCKED and clear the word timer.
  - Misaligned comma: pulse `align_err`, realign to it, emit it, set good = 1.
  - `CHECK_TIMEOUT` consecutive non-comma words: go to HUNT.
- LOCKED:
  - Emit every boundary word.
  - Aligned comma: clear the miss count.
  - Misaligned comma: pulse `align_err`, miss+1, no realign and no emit. When miss reaches `MISALIGN_MAX`, go to HUNT and deassert `locked`.
- A comma match on a boundary is always aligned, never both aligned and misaligned.
- `enable` low:
  - `sr`, counters, state and all outputs clear to reset values at the next edge.
  - No shifting occurs.
  - Re-enabling restarts in HUNT.
- Reset (`rst` high, asynchronous, any time including mid-word):
  - `sr=0`, state HUNT, counters 0.
  - `data_out=0`, `data_valid=0`, `is_comma=0`, `locked=0`, `align_err=0`.

## Timing
- Latency: a symbol whose last bit is sampled at edge E appears on `data_out` with `data_valid=1` after edge E+1.
- While aligned, `data_valid` pulses exactly every 10 cycles. Between pulses, `data_out` holds the last word.
- `locked` rises in the same cycle as the `data_valid` of the `LOCK_COMMAS`-th aligned comma.
- `locked` falls in the same cycle as the `align_err` of the `MISALIGN_MAX`-th miss.
- `align_err` and `data_valid` are never high together in LOCKED. In CHECK they may coincide on a realign.
- Counters saturate; they never wrap.

## Structure
- Shared package `serdes_pkg`:
  - `K28_5_RDN = 10'b0011111010` and `K28_5_RDP = 10'b1100000101`.
  - State enum `align_state_t {HUNT, CHECK, LOCKED}`.
  - Symbol width constant 10, shared with the serialiser.
- One sub-module, `serdes_comma_det`: combinational, 10-bit input, match output. It is reused by the serialiser-side checker.
- Top-level holds the shift register, word counter, FSM and output registers.

## Test plan
- Reset release, `enable=1`, idle ones on `serdes_rx` for 40 cycles -> `data_valid`, `locked` and `align_err` stay 0; `data_out=10'h000`.
- Serialise K28.5 RD- three times back-to-back after 3 garbage bits:
  - `data_valid` pulses at +1, +11 and +21 cycles after the first comma completes, each with `data_out=10'h0FA` and `is_comma=1`.
  - `locked` rises with the third pulse.
- Locked, then a stream of data words `10'h2AA` -> `data_valid` every 10 cycles with `data_out=10'h2AA`, `is_comma=0`, `locked` stays 1.
- Locked, then insert one bit slip before two K28.5 words:
  - two `align_err` pulses.
  - `locked` falls on the second.
  - The next comma re-enters CHECK with `data_valid`.
- In CHECK, send 16 non-comma words -> state returns to HUNT and `data_valid` stops.
- Assert `rst` mid-word while locked, and separately drop `enable` for one cycle:
  - Every output is 0 immediately for `rst`, and at the next edge for `enable`.
  - Relock needs `LOCK_COMMAS` fresh commas.
